// File: rtl/cordic_sincos_bank_pkg.sv
// Shared CORDIC definitions: fixed-point types, angle constants, arctangent
// table generator, CORDIC gain compensation and the bank FSM state encoding.
// The constant generators work internally at 60 fraction bits. They then round
// the result to the requested format, so they support formats up to 59
// fraction bits and up to 64 bits wide.
package cordic_sincos_bank_pkg;

  typedef logic signed [63:0] fx64_t;
  typedef logic [127:0]       wide_t;

  // Reference precision of the constant generators.
  localparam int CFW = 60;
  // pi in Q4.60 (truncated).
  localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REDUCE = 3'd2,
    ST_ROTATE = 3'd3,
    ST_STORE  = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  // Round a Q.60 value to fw fraction bits.
  function automatic logic [63:0] q60_to_fw(input logic [63:0] v, input int fw);
    logic [63:0] half;
    half = 64'd1 << (CFW - fw - 1);
    return (v + half) >> (CFW - fw);
  endfunction

  function automatic logic [63:0] pi_c(input int fw);
    return q60_to_fw(PI_Q60, fw);
  endfunction

  function automatic logic [63:0] pi_2_c(input int fw);
    return q60_to_fw(PI_Q60 >> 1, fw);
  endfunction

  function automatic logic [63:0] pi3_2_c(input int fw);
    return q60_to_fw(PI_Q60 + (PI_Q60 >> 1), fw);
  endfunction

  function automatic logic [63:0] two_pi_c(input int fw);
    return q60_to_fw(PI_Q60 << 1, fw);
  endfunction

  // atan(2^-i) rounded to fw fraction bits; zero once 2^-i falls below one LSB.
  // Uses the alternating Taylor series x - x^3/3 + x^5/5 ... with x = 2^-i.
  function automatic logic [63:0] atan_lut(input int i, input int fw);
    wide_t acc;
    wide_t term;
    logic [63:0] v;
    acc = '0;
    if (i >= fw) begin
      v = 64'd0;
    end else if (i == 0) begin
      v = PI_Q60 >> 2;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (i * (2 * k + 1) <= CFW) begin
          term = (wide_t'(1) << (CFW - i * (2 * k + 1))) / wide_t'(2 * k + 1);
          if (k % 2 == 0) acc = acc + term;
          else            acc = acc - term;
        end else begin
          acc = acc;
        end
      end
      v = acc[63:0];
    end
    if (i >= fw) return 64'd0;
    else         return q60_to_fw(v, fw);
  endfunction

  // 1/K = prod_{i<n} 1/sqrt(1+2^-2i), rounded to fw fraction bits.
  // The square of the product is formed first, then a bit-serial integer sqrt.
  function automatic logic [63:0] kinv_c(input int n, input int fw);
    wide_t one;
    wide_t k2;
    wide_t rem;
    wide_t root;
    wide_t cand;
    one = wide_t'(1) << CFW;
    k2  = one;
    for (int i = 0; i < 64; i++) begin
      if (i < n) k2 = (k2 * one) / (one + (one >> (2 * i)));
      else       k2 = k2;
    end
    rem  = k2 * one;
    root = '0;
    for (int b = 62; b >= 0; b--) begin
      cand = root | (wide_t'(1) << b);
      if (cand * cand <= rem) root = cand;
      else                    root = root;
    end
    return q60_to_fw(root[63:0], fw);
  endfunction

endpackage

// File: rtl/cordic_sincos_bank_iter.sv
// One combinational CORDIC micro-rotation in rotation mode: drives z toward 0
// and rotates (x,y) by -/+ atan(2^-i).
module cordic_sincos_bank_iter
  import cordic_sincos_bank_pkg::*;
#(
  parameter int DW    = 64,
  parameter int FW_IN = 44,
  parameter int IW    = $clog2(FW_IN + 1)
) (
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  input  logic signed [DW-1:0] z_i,
  input  logic [IW-1:0]        i_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic signed [DW-1:0] z_o
);

  // The table covers every value of i_i; entries past FW_IN evaluate to zero.
  logic [DW-1:0] atan_rom [2**IW];

  for (genvar g = 0; g < 2**IW; g++) begin : g_atan
    assign atan_rom[g] = DW'(atan_lut(g, FW_IN));
  end

  logic signed [DW-1:0] xs_s;
  logic signed [DW-1:0] ys_s;
  logic signed [DW-1:0] at_s;

  // Shift-and-add rotation; the sign of z selects the rotation direction.
  always_comb begin
    xs_s = x_i >>> i_i;
    ys_s = y_i >>> i_i;
    at_s = $signed(atan_rom[i_i]);
    if (z_i >= 0) begin
      x_o = x_i - ys_s;
      y_o = y_i + xs_s;
      z_o = z_i - at_s;
    end else begin
      x_o = x_i + ys_s;
      y_o = y_i - xs_s;
      z_o = z_i + at_s;
    end
  end

endmodule

// File: rtl/cordic_sincos_bank.sv
// Iterative CORDIC sin/cos bank. One start request snapshots NF angles. The
// bank then walks them with a single micro-rotation stage and writes cos, sin
// and 2*cos for each channel.
module cordic_sincos_bank
  import cordic_sincos_bank_pkg::*;
#(
  parameter int NF     = 11,
  parameter int DW     = 64,
  parameter int FW_IN  = 44,
  parameter int FW_OUT = 32,
  parameter int NITER  = 44
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [NF*DW-1:0] ang_i,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [NF*DW-1:0] cos_o,
  output logic [NF*DW-1:0] sin_o,
  output logic [NF*DW-1:0] alpha_o
);

  localparam int IW = $clog2(FW_IN + 1);
  localparam int XW = (NF > 1) ? $clog2(NF) : 1;
  localparam int SH = FW_IN - FW_OUT;

  localparam logic signed [DW-1:0] PI_C     = DW'(pi_c(FW_IN));
  localparam logic signed [DW-1:0] PI_2_C   = DW'(pi_2_c(FW_IN));
  localparam logic signed [DW-1:0] PI3_2_C  = DW'(pi3_2_c(FW_IN));
  localparam logic signed [DW-1:0] TWO_PI_C = DW'(two_pi_c(FW_IN));
  localparam logic signed [DW-1:0] KINV_C   = DW'(kinv_c(NITER, FW_IN));
  // Half an output LSB. It is zero when the formats match, which makes the
  // rounding a plain shift.
  localparam logic signed [DW-1:0] RND_ADD  = (DW'(1) << SH) >> 1;

  state_e               state_q, state_d;
  logic [XW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        i_q, i_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                 neg_q, neg_d;
  logic [NF*DW-1:0]     snap_q, snap_d;
  logic [NF*DW-1:0]     cos_q, cos_d, sin_q, sin_d, alpha_q, alpha_d;
  logic                 busy_q, busy_d, done_q, done_d, valid_q, valid_d;

  logic signed [DW-1:0] xn_s, yn_s, zn_s;
  logic signed [DW-1:0] c_s, s_s, cr_s, sr_s;

  cordic_sincos_bank_iter #(.DW(DW), .FW_IN(FW_IN), .IW(IW)) u_iter (
    .x_i(x_q), .y_i(y_q), .z_i(z_q), .i_i(i_q),
    .x_o(xn_s), .y_o(yn_s), .z_o(zn_s)
  );

  // Next-state logic: sequencing of channels, the datapath and the result banks.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    snap_d  = snap_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    alpha_d = alpha_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    c_s     = (x_q + RND_ADD) >>> SH;
    s_s     = (y_q + RND_ADD) >>> SH;
    cr_s    = neg_q ? -c_s : c_s;
    sr_s    = neg_q ? -s_s : s_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = ang_i;
          idx_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        z_d     = $signed(snap_q[int'(idx_q)*DW +: DW]);
        x_d     = KINV_C;
        y_d     = '0;
        i_d     = '0;
        state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        // Fold the angle into [-pi/2, pi/2]. A half-turn fold flips the sign of the result.
        if (z_q >= PI3_2_C) begin
          z_d   = z_q - TWO_PI_C;
          neg_d = 1'b0;
        end else if (z_q > PI_2_C) begin
          z_d   = z_q - PI_C;
          neg_d = 1'b1;
        end else begin
          neg_d = 1'b0;
        end
        state_d = ST_ROTATE;
      end
      ST_ROTATE: begin
        x_d = xn_s;
        y_d = yn_s;
        z_d = zn_s;
        i_d = i_q + IW'(1);
        if (i_q == IW'(NITER - 1)) state_d = ST_STORE;
        else                       state_d = ST_ROTATE;
      end
      ST_STORE: begin
        cos_d[int'(idx_q)*DW +: DW]   = cr_s;
        sin_d[int'(idx_q)*DW +: DW]   = sr_s;
        alpha_d[int'(idx_q)*DW +: DW] = cr_s <<< 1;
        idx_d = idx_q + XW'(1);
        if (idx_q == XW'(NF - 1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and result registers; reset clears everything, including the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      snap_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      alpha_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      snap_q  <= snap_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      alpha_q <= alpha_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;
  assign cos_o   = cos_q;
  assign sin_o   = sin_q;
  assign alpha_o = alpha_q;

endmodule

// File: tb/tb_cordic_sincos_bank.sv
// Bench for cordic_sincos_bank: directed angle sets, ignored-start and
// mid-run reset cases, then random angles. Results are compared against
// real-valued sin/cos.
module tb_cordic_sincos_bank;

  localparam int NF     = 11;
  localparam int DW     = 64;
  localparam int FW_IN  = 44;
  localparam int FW_OUT = 32;
  localparam int NITER  = 44;
  localparam int LAT    = NF * (NITER + 3) + 1;

  localparam real M_PI  = 3.14159265358979323846;
  localparam real SC_IN = 17592186044416.0;  // 2^44
  localparam real SC_OUT = 4294967296.0;     // 2^32

  logic             clk;
  logic             rstn;
  logic             start;
  logic [NF*DW-1:0] ang_i;
  logic             busy;
  logic             done;
  logic             valid;
  logic [NF*DW-1:0] cos_o;
  logic [NF*DW-1:0] sin_o;
  logic [NF*DW-1:0] alpha_o;

  int     n_vec;
  int     n_err;
  longint ang_v [NF];

  cordic_sincos_bank #(
    .NF(NF), .DW(DW), .FW_IN(FW_IN), .FW_OUT(FW_OUT), .NITER(NITER)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .ang_i(ang_i),
    .busy(busy), .done(done), .valid(valid),
    .cos_o(cos_o), .sin_o(sin_o), .alpha_o(alpha_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    longint d;
    n_vec++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint ang_q(input real r);
    return longint'(r * SC_IN);
  endfunction

  // Compare every channel against the mathematical sin/cos of its angle.
  task automatic check_outputs(input string tag);
    real th;
    for (int ch = 0; ch < NF; ch++) begin
      th = real'(ang_v[ch]) / SC_IN;
      chk($sformatf("%s cos[%0d]", tag, ch), $signed(cos_o[ch*DW +: DW]),
          longint'($cos(th) * SC_OUT), 4);
      chk($sformatf("%s sin[%0d]", tag, ch), $signed(sin_o[ch*DW +: DW]),
          longint'($sin(th) * SC_OUT), 4);
      chk($sformatf("%s alpha[%0d]", tag, ch), $signed(alpha_o[ch*DW +: DW]),
          longint'(2.0 * $cos(th) * SC_OUT), 8);
    end
  endtask

  // One complete run. Optionally re-pulses start and scrambles ang_i mid-run.
  // It also pulses start in the done cycle, which must be ignored.
  task automatic run_bank(input string tag, input bit disturb, input bit exp_valid);
    int n;
    for (int ch = 0; ch < NF; ch++) ang_i[ch*DW +: DW] = ang_v[ch];
    chk({tag, " valid_pre"}, valid, exp_valid, 0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < NF * DW / 32; w++) ang_i[w*32 +: 32] = $urandom;
    start = 1'b0;
    n = 1;
    chk({tag, " busy_start"}, busy, 1, 0);
    chk({tag, " valid_start"}, valid, 0, 0);
    while (done !== 1'b1 && n < LAT + 20) begin
      start = disturb && (n == 10);
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, LAT, 0);
    chk({tag, " busy_fin"}, busy, 0, 0);
    chk({tag, " valid_fin"}, valid, 1, 0);
    check_outputs(tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_width"}, done, 0, 0);
    chk({tag, " start_at_done"}, busy, 0, 0);
    chk({tag, " valid_hold"}, valid, 1, 0);
    repeat (3) @(negedge clk);
    chk({tag, " valid_idle"}, valid, 1, 0);
  endtask

  initial begin
    int n;
    longint two_pi_q;
    longint unsigned r;
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    start = 1'b0;
    ang_i = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0, 0);
    chk("rst done", done, 0, 0);
    chk("rst valid", valid, 0, 0);
    chk("rst outs", longint'(|{cos_o, sin_o, alpha_o}), 0, 0);
    rstn = 1'b1;
    @(negedge clk);

    // All angles zero: cos=1, sin=0, alpha=2.
    for (int ch = 0; ch < NF; ch++) ang_v[ch] = 0;
    run_bank("zero", 1'b0, 1'b0);
    chk("zero cos0 exact", $signed(cos_o[0 +: DW]), 64'sh1_0000_0000, 4);

    // The fold boundaries and each fold branch.
    ang_v[0] = ang_q(M_PI / 2.0);       ang_v[1] = ang_q(M_PI);
    ang_v[2] = ang_q(1.5 * M_PI);       ang_v[3] = ang_q(M_PI / 2.0) + 1;
    ang_v[4] = ang_q(M_PI / 2.0) - 1;   ang_v[5] = ang_q(1.5 * M_PI) - 1;
    ang_v[6] = ang_q(1.5 * M_PI) + 1;   ang_v[7] = ang_q(0.25 * M_PI);
    ang_v[8] = ang_q(1.25 * M_PI);      ang_v[9] = ang_q(2.0 * M_PI) - 1;
    ang_v[10] = 1;
    run_bank("axes", 1'b0, 1'b1);

    // 7pi/4 and 3pi/4 alternating.
    for (int ch = 0; ch < NF; ch++) ang_v[ch] = ang_q((ch % 2 == 0) ? 1.75 * M_PI : 0.75 * M_PI);
    run_bank("diag", 1'b0, 1'b1);

    // start pulse mid-run and ang_i changes after the start cycle.
    two_pi_q = ang_q(2.0 * M_PI);
    for (int ch = 0; ch < NF; ch++) begin
      r = {$urandom, $urandom};
      ang_v[ch] = longint'(r % longint'(two_pi_q));
    end
    run_bank("snap", 1'b1, 1'b1);

    // Reset during the rotations of channel 5 aborts everything at once.
    for (int ch = 0; ch < NF; ch++) ang_i[ch*DW +: DW] = ang_q(1.0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 5 * (NITER + 3) + 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort busy_pre", busy, 1, 0);
    rstn = 1'b0;
    #1;
    chk("abort busy", busy, 0, 0);
    chk("abort done", done, 0, 0);
    chk("abort valid", valid, 0, 0);
    chk("abort outs", longint'(|{cos_o, sin_o, alpha_o}), 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < NF; ch++) ang_v[ch] = ang_q(0.3 + 0.5 * ch);
    run_bank("post_rst", 1'b0, 1'b0);

    // Random angles over the full range.
    for (int run = 0; run < 50; run++) begin
      for (int ch = 0; ch < NF; ch++) begin
        r = {$urandom, $urandom};
        ang_v[ch] = longint'(r % longint'(two_pi_q));
      end
      run_bank($sformatf("rnd%0d", run), 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
